vga_frame_scheduler: RTL

VGA_FRAME_SCHEDULER -- requirements
Module: vga_frame_scheduler

---
 rtl/vga_frame_scheduler.sv | 83 ++++++++
 1 files changed

// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler: arbitrates screen/note redraw requests and sweeps one full-frame ROM copy per grant
module vga_frame_scheduler #(
  parameter int H_PIX = 160,
  parameter int V_PIX = 120
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        scr_valid,
  input  logic [4:0]  scr_rom,
  output logic        scr_ready,
  input  logic        note_valid,
  input  logic [4:0]  note_rom,
  output logic        note_ready,
  output logic [14:0] rom_addr,
  output logic [4:0]  sel_rom,
  output logic [7:0]  x,
  output logic [7:0]  y,
  output logic        writeEn,
  output logic        busy,
  output logic        frame_done
);
  localparam logic [7:0] H_LAST = 8'(H_PIX - 1);
  localparam logic [7:0] V_LAST = 8'(V_PIX - 1);
  typedef enum logic [1:0] {IDLE, SWEEP, FLUSH} state_t;
  state_t state, state_n;
  logic scr_pend, note_pend;
  logic [4:0] scr_sel, note_sel;
  logic [7:0] col, row;
  logic last, grant_scr, grant_note;
  assign scr_ready  = !scr_pend;
  assign note_ready = !note_pend;
  assign busy       = state != IDLE;
  assign last       = col == H_LAST && row == V_LAST;
  assign grant_scr  = state == IDLE && scr_pend;
  assign grant_note = state == IDLE && !scr_pend && note_pend;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? ((scr_pend || note_pend) ? SWEEP : IDLE) :
              state == SWEEP ? (last ? FLUSH : SWEEP) : IDLE;
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      scr_pend   <= 1'b0;
      note_pend  <= 1'b0;
      scr_sel    <= 5'd0;
      note_sel   <= 5'd0;
      sel_rom    <= 5'd2;
      col        <= 8'd0;
      row        <= 8'd0;
      rom_addr   <= 15'd0;
      x          <= 8'd0;
      y          <= 8'd0;
      writeEn    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // A full slot ignores valid, so an accepted request can never be overwritten
      scr_pend  <= grant_scr  ? 1'b0 : (scr_pend  | scr_valid);
      note_pend <= grant_note ? 1'b0 : (note_pend | note_valid);
      if (scr_valid && !scr_pend)   scr_sel  <= scr_rom;
      if (note_valid && !note_pend) note_sel <= note_rom;
      writeEn    <= state == SWEEP;
      frame_done <= state == FLUSH;
      if (state == SWEEP) begin
        x <= col;
        y <= row;
      end
      if (grant_scr || grant_note) begin
        sel_rom  <= grant_scr ? scr_sel : note_sel;
        col      <= 8'd0;
        row      <= 8'd0;
        rom_addr <= 15'd0;
      end else if (state == SWEEP && !last) begin
        col      <= col == H_LAST ? 8'd0 : col + 8'd1;
        row      <= col == H_LAST ? row + 8'd1 : row;
        rom_addr <= rom_addr + 15'd1;
      end
    end
  end
endmodule
